video_rx_monitor: RTL

Receive-side companion to the sprite engine's video output: a TinyQV peripheral that samples an XGA-style stream (active-high hsync/vsync, 2-bit R/G/B) on its input PMOD. Per frame it measures line and frame lengths, declares lock against nominal timing, counts lit pixels, and reports their bounding box in 256x192 logical coordinates. Results are latched into readable shadow registers at each frame boundary, with an optional frame-done interrupt. It serves as an on-chip loopback checker and capture front end for video sources built on the same 6-wire-colour + sync pinout.

---
 rtl/video_rx_monitor.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/video_rx_monitor.sv
// rtl/video_rx_monitor.sv - sync timing, lock, lit-pixel count and bounding-box monitor for a 6-bit RGB video input
module video_rx_monitor (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    localparam logic [10:0] H_TOTAL  = 11'd1344;
    localparam logic [9:0]  V_TOTAL  = 10'd806;
    localparam logic [10:0] H_START  = 11'd296;
    localparam logic [9:0]  V_START  = 10'd35;
    localparam logic [10:0] H_ACTIVE = 11'd1024;
    localparam logic [9:0]  V_ACTIVE = 10'd768;

    localparam logic [5:0] A_CTRL   = 6'h00;
    localparam logic [5:0] A_HTOTAL = 6'h04;
    localparam logic [5:0] A_VTOTAL = 6'h08;
    localparam logic [5:0] A_LIT    = 6'h0C;
    localparam logic [5:0] A_BBOX   = 6'h10;
    localparam logic [5:0] A_FCNT   = 6'h14;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic        hs_q, hs_d, vs_q, vs_d;
    logic        en_q, en_d, irq_en_q, irq_en_d, irq_flag_q, irq_flag_d;
    logic        locked_q, locked_d;
    logic [10:0] hcnt_q, hcnt_d, meas_h_q, meas_h_d;
    logic [9:0]  vline_q, vline_d;
    logic [19:0] lit_acc_q, lit_acc_d;
    logic [7:0]  xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
    logic [10:0] sh_htotal_q, sh_htotal_d;
    logic [9:0]  sh_vtotal_q, sh_vtotal_d;
    logic [19:0] sh_lit_q, sh_lit_d;
    logic [31:0] sh_bbox_q, sh_bbox_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic        hs_rise, vs_rise, running, frame_end, wr_ctrl;
    logic        active, pix_lit;
    logic [10:0] hcnt_inc, x_off, meas_eff;
    logic [9:0]  vline_inc, y_off, vline_eff;
    logic [7:0]  lx, ly;
    logic [19:0] lit_acc_eff;
    logic [7:0]  xmin_eff, xmax_eff, ymin_eff, ymax_eff;
    logic        unused_inputs;

    assign hs_rise   = ui_in[6] & ~hs_q;
    assign vs_rise   = ui_in[7] & ~vs_q;
    assign running   = en_q && (state_q != S_IDLE);
    assign frame_end = running && (state_q == S_RUN) && vs_rise;
    assign wr_ctrl   = (data_write_n != 2'b11) && (address == A_CTRL);

    assign hcnt_inc  = (hcnt_q == 11'h7FF) ? hcnt_q : hcnt_q + 11'd1;
    assign vline_inc = (vline_q == 10'h3FF) ? vline_q : vline_q + 10'd1;

    // A line ending in the same cycle as the frame is still counted into that frame.
    assign meas_eff  = hs_rise ? hcnt_inc : meas_h_q;
    assign vline_eff = hs_rise ? vline_inc : vline_q;

    assign active  = (hcnt_q >= H_START) && (hcnt_q < H_START + H_ACTIVE) &&
                     (vline_q >= V_START) && (vline_q < V_START + V_ACTIVE);
    assign x_off   = hcnt_q - H_START;
    assign y_off   = vline_q - V_START;
    assign lx      = x_off[9:2];
    assign ly      = y_off[9:2];
    assign pix_lit = active && (ui_in[5:0] != 6'd0);

    always_comb begin : pixel_accumulate
        lit_acc_eff = lit_acc_q;
        xmin_eff    = xmin_q;
        xmax_eff    = xmax_q;
        ymin_eff    = ymin_q;
        ymax_eff    = ymax_q;
        if (pix_lit) begin
            if (lit_acc_q != 20'hFFFFF) begin
                lit_acc_eff = lit_acc_q + 20'd1;
            end
            if (lx < xmin_q) xmin_eff = lx;
            if (lx > xmax_q) xmax_eff = lx;
            if (ly < ymin_q) ymin_eff = ly;
            if (ly > ymax_q) ymax_eff = ly;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en_q) state_d = S_ARMED;
            S_ARMED: if (vs_rise) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
        if (!en_q) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin : next_data
        hs_d        = ui_in[6];
        vs_d        = ui_in[7];
        en_d        = en_q;
        irq_en_d    = irq_en_q;
        irq_flag_d  = irq_flag_q;
        locked_d    = locked_q;
        hcnt_d      = hcnt_q;
        meas_h_d    = meas_h_q;
        vline_d     = vline_q;
        lit_acc_d   = lit_acc_q;
        xmin_d      = xmin_q;
        xmax_d      = xmax_q;
        ymin_d      = ymin_q;
        ymax_d      = ymax_q;
        sh_htotal_d = sh_htotal_q;
        sh_vtotal_d = sh_vtotal_q;
        sh_lit_d    = sh_lit_q;
        sh_bbox_d   = sh_bbox_q;
        frame_cnt_d = frame_cnt_q;

        if (wr_ctrl) begin
            en_d     = data_in[0];
            irq_en_d = data_in[1];
            if (data_in[2]) irq_flag_d = 1'b0;
        end

        if (!running) begin
            hcnt_d    = 11'd0;
            meas_h_d  = 11'd0;
            vline_d   = 10'd0;
            lit_acc_d = 20'd0;
            xmin_d    = 8'hFF;
            xmax_d    = 8'h00;
            ymin_d    = 8'hFF;
            ymax_d    = 8'h00;
            locked_d  = 1'b0;
        end else begin
            hcnt_d    = hs_rise ? 11'd0 : hcnt_inc;
            meas_h_d  = meas_eff;
            vline_d   = vs_rise ? 10'd0 : vline_eff;
            lit_acc_d = lit_acc_eff;
            xmin_d    = xmin_eff;
            xmax_d    = xmax_eff;
            ymin_d    = ymin_eff;
            ymax_d    = ymax_eff;
            if (vs_rise) begin
                lit_acc_d = 20'd0;
                xmin_d    = 8'hFF;
                xmax_d    = 8'h00;
                ymin_d    = 8'hFF;
                ymax_d    = 8'h00;
            end
            if (frame_end) begin
                sh_htotal_d = meas_eff;
                sh_vtotal_d = vline_eff;
                sh_lit_d    = lit_acc_eff;
                sh_bbox_d   = {ymax_eff, xmax_eff, ymin_eff, xmin_eff};
                frame_cnt_d = frame_cnt_q + 16'd1;
                locked_d    = (meas_eff == H_TOTAL) && (vline_eff == V_TOTAL);
            end
        end

        // Applied after the W1C so a frame-end set wins over a same-cycle clear.
        if (frame_end && irq_en_q) begin
            irq_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            en_q        <= 1'b0;
            irq_en_q    <= 1'b0;
            irq_flag_q  <= 1'b0;
            locked_q    <= 1'b0;
            hcnt_q      <= 11'd0;
            meas_h_q    <= 11'd0;
            vline_q     <= 10'd0;
            lit_acc_q   <= 20'd0;
            xmin_q      <= 8'hFF;
            xmax_q      <= 8'h00;
            ymin_q      <= 8'hFF;
            ymax_q      <= 8'h00;
            sh_htotal_q <= 11'd0;
            sh_vtotal_q <= 10'd0;
            sh_lit_q    <= 20'd0;
            sh_bbox_q   <= 32'h0000FFFF;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            en_q        <= en_d;
            irq_en_q    <= irq_en_d;
            irq_flag_q  <= irq_flag_d;
            locked_q    <= locked_d;
            hcnt_q      <= hcnt_d;
            meas_h_q    <= meas_h_d;
            vline_q     <= vline_d;
            lit_acc_q   <= lit_acc_d;
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymin_q      <= ymin_d;
            ymax_q      <= ymax_d;
            sh_htotal_q <= sh_htotal_d;
            sh_vtotal_q <= sh_vtotal_d;
            sh_lit_q    <= sh_lit_d;
            sh_bbox_q   <= sh_bbox_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin : read_mux
        data_out = 32'd0;
        case (address)
            A_CTRL:   data_out = {28'd0, locked_q, irq_flag_q, irq_en_q, en_q};
            A_HTOTAL: data_out = {21'd0, sh_htotal_q};
            A_VTOTAL: data_out = {22'd0, sh_vtotal_q};
            A_LIT:    data_out = {12'd0, sh_lit_q};
            A_BBOX:   data_out = sh_bbox_q;
            A_FCNT:   data_out = {16'd0, frame_cnt_q};
            default:  data_out = 32'd0;
        endcase
    end

    assign uo_out         = 8'h00;
    assign data_ready     = 1'b1;
    assign user_interrupt = irq_flag_q;

    assign unused_inputs = ^{data_read_n, data_in[31:8], x_off[10], x_off[1:0], y_off[1:0]};

endmodule
